// File: rtl/pix_dbuf.sv
// pix_dbuf - double-buffered (ping-pong) RGB pixel buffer.
//
// The pixel source writes into the back bank while scan-out reads the front
// bank. A swap request is held pending until the next frame boundary and then
// committed one cycle later. A built-in sequencer zeroes the whole back bank
// on demand, one address per cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   wr_en      pixel write strobe (back bank)
//   wr_addr    write pixel address
//   wr_data    packed pixel: [CW-1:0]=R, [2CW-1:CW]=B, [3CW-1:2CW]=G
//   wr_be      channel enables: bit0=R, bit1=B, bit2=G
//   rd_en      pixel read strobe (front bank)
//   rd_addr    read pixel address
//   R0/B0/G0   registered read data, one cycle after rd_en
//   rd_valid   registered read-data valid
//   swap_req   one-cycle request to swap banks at the next frame boundary
//   frame_end  one-cycle frame-boundary pulse
//   swap_done  one-cycle pulse on the cycle after the swap commits
//   front_sel  index of the bank currently being read
//   clr_start  one-cycle request to clear the back bank
//   clr_busy   high while the clear sequencer runs

module pix_dbuf #(
  parameter int CW     = 8,
  parameter int DEPTH  = 10000,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3*CW-1:0]   wr_data,
  input  logic [2:0]        wr_be,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CW-1:0]     R0,
  output logic [CW-1:0]     B0,
  output logic [CW-1:0]     G0,
  output logic              rd_valid,
  input  logic              swap_req,
  input  logic              frame_end,
  output logic              swap_done,
  output logic              front_sel,
  input  logic              clr_start,
  output logic              clr_busy
);

  localparam int WORDS = 2 * DEPTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  // Range checks are done one bit wider than the address so that
  // DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_I  = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_COMMIT
  } swap_state_t;

  swap_state_t swap_state;

  // One array per channel so that per-channel write enables need no
  // read-modify-write.
  logic [CW-1:0] mem_r [WORDS];
  logic [CW-1:0] mem_b [WORDS];
  logic [CW-1:0] mem_g [WORDS];

  logic             back_sel;
  logic             wr_in_range;
  logic             rd_in_range;
  logic [IDX_W-1:0] wr_off;
  logic [IDX_W-1:0] rd_off;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] clr_cnt;

  logic             mem_we_r;
  logic             mem_we_b;
  logic             mem_we_g;
  logic [IDX_W-1:0] mem_widx;
  logic [CW-1:0]    mem_wd_r;
  logic [CW-1:0]    mem_wd_b;
  logic [CW-1:0]    mem_wd_g;

  // Bank b, address a lives at word b*DEPTH + a.
  function automatic logic [IDX_W-1:0] word_idx(input logic bank,
                                               input logic [IDX_W-1:0] offs);
    return bank ? (DEPTH_I + offs) : offs;
  endfunction

  assign back_sel    = ~front_sel;
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);

  // Offsets are only used when in range, where they always fit in IDX_W.
  assign wr_off = IDX_W'(wr_addr);
  assign rd_off = IDX_W'(rd_addr);
  assign rd_idx = word_idx(front_sel, rd_off);

  // Single shared write port: the clear sequencer owns it while busy, so
  // pixel writes during a clear are simply dropped.
  always_comb begin
    mem_we_r = 1'b0;
    mem_we_b = 1'b0;
    mem_we_g = 1'b0;
    mem_widx = '0;
    mem_wd_r = '0;
    mem_wd_b = '0;
    mem_wd_g = '0;
    if (clr_busy) begin
      mem_we_r = 1'b1;
      mem_we_b = 1'b1;
      mem_we_g = 1'b1;
      mem_widx = word_idx(back_sel, clr_cnt);
    end else if (wr_en && wr_in_range) begin
      mem_we_r = wr_be[0];
      mem_we_b = wr_be[1];
      mem_we_g = wr_be[2];
      mem_widx = word_idx(back_sel, wr_off);
      mem_wd_r = wr_data[CW-1:0];
      mem_wd_b = wr_data[2*CW-1:CW];
      mem_wd_g = wr_data[3*CW-1:2*CW];
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_r) mem_r[mem_widx] <= mem_wd_r;
    if (mem_we_b) mem_b[mem_widx] <= mem_wd_b;
    if (mem_we_g) mem_g[mem_widx] <= mem_wd_g;
  end

  // Registered read port on the front bank; out-of-range reads return zero
  // but still report valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      R0       <= '0;
      B0       <= '0;
      G0       <= '0;
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_valid <= 1'b1;
      if (rd_in_range) begin
        R0 <= mem_r[rd_idx];
        B0 <= mem_b[rd_idx];
        G0 <= mem_g[rd_idx];
      end else begin
        R0 <= '0;
        B0 <= '0;
        G0 <= '0;
      end
    end else begin
      rd_valid <= 1'b0;
    end
  end

  // Clear sequencer: busy for exactly DEPTH cycles, walking 0..DEPTH-1.
  // A new clr_start while busy is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_busy <= 1'b0;
      clr_cnt  <= '0;
    end else if (clr_busy) begin
      if (clr_cnt == LAST_I) begin
        clr_busy <= 1'b0;
        clr_cnt  <= '0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end else if (clr_start) begin
      clr_busy <= 1'b1;
      clr_cnt  <= '0;
    end
  end

  // Swap FSM. A frame boundary seen during a clear does not commit, so the
  // banks never change under a half-finished clear. swap_req outside IDLE
  // is dropped rather than queued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      swap_state <= S_IDLE;
      front_sel  <= 1'b0;
      swap_done  <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      unique case (swap_state)
        S_IDLE: begin
          if (swap_req) swap_state <= S_PEND;
        end
        S_PEND: begin
          if (frame_end && !clr_busy) swap_state <= S_COMMIT;
        end
        S_COMMIT: begin
          front_sel  <= ~front_sel;
          swap_done  <= 1'b1;
          swap_state <= S_IDLE;
        end
        default: swap_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pix_dbuf.md
# pix_dbuf

Parametrised double-buffered (ping-pong) RGB pixel buffer for the display adapter datapath. The pixel source writes into the back bank while the scan-out side reads the front bank. Banks swap only on a frame boundary after a swap request. A built-in sequencer clears the back bank on demand. The block replaces the single-bank RGB buffer with per-channel write enables, registered read-valid and out-of-range protection.

## Interface
- CW, 8: bits per colour channel
- DEPTH, 10000: pixels per bank
- ADDR_W, 20: address width; DEPTH ≤ 2^ADDR_W
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; one clock domain
- wr_en  in  1  pixel write strobe
- wr_addr  in  ADDR_W  write pixel address, back bank
- wr_data  in  3*CW  packed pixel: [CW-1:0]=R, [2CW-1:CW]=B, [3CW-1:2CW]=G
- wr_be  in  3  channel enables: bit0=R, bit1=B, bit2=G
- rd_en  in  1  pixel read strobe
- rd_addr  in  ADDR_W  read pixel address, front bank
- R0, B0, G0  out  CW each  read data, registered
- rd_valid  out  1  read data valid
- swap_req  in  1  one-cycle request to swap banks at the next frame boundary
- frame_end  in  1  one-cycle frame-boundary pulse from scan-out timing
- swap_done  out  1  one-cycle pulse on the cycle after the swap commits
- front_sel  out  1  index of the bank currently being read
- clr_start  in  1  one-cycle request to clear the back bank
- clr_busy  out  1  high while the clear sequencer runs

## Operation
- Storage is 2*DEPTH words of 3*CW bits. Bank b, address a is word b*DEPTH+a. The back bank is !front_sel.
- Write: when wr_en=1, clr_busy=0 and wr_addr<DEPTH, each channel with its wr_be bit set is written to the back bank. Channels with a clear bit keep their old value.
- A write with wr_addr≥DEPTH is dropped. A write while clr_busy=1 is dropped.
- Read: when rd_en=1, the front bank is read.
  - If rd_addr<DEPTH, the stored R, B and G go to R0, B0 and G0.
  - If rd_addr≥DEPTH, the outputs are all zero.
  - rd_valid is 1 in both cases.
- Read and write never address the same bank, so simultaneous rd_en and wr_en need no priority logic.
- Swap FSM states:
  - IDLE to PEND on swap_req.
  - PEND to COMMIT on frame_end while clr_busy=0. frame_end seen during a clear is ignored; the FSM stays in PEND.
  - COMMIT toggles front_sel, pulses swap_done and returns to IDLE.
  - swap_req in PEND or COMMIT is ignored and is not queued.
  - swap_req and frame_end in the same cycle while in IDLE: the FSM enters PEND only. The swap commits on the following frame_end.
- Clear sequencer:
  - clr_start while idle sets clr_busy and a counter to 0.
  - Each busy cycle writes zero to all three channels at the back bank, counter address.
  - The sequencer stops after address DEPTH-1, so clr_busy is high for exactly DEPTH cycles.
  - clr_start while busy is ignored.
  - Reads are unaffected by a clear.
- The memory array is not reset. Reset aborts any clear in progress and leaves the memory contents undefined.

## Timing
- Reset values: R0=B0=G0=0, rd_valid=0, front_sel=0, swap_done=0, clr_busy=0. Swap FSM resets to IDLE and the clear counter to 0.
- Read latency is 1. rd_en sampled at edge N gives data and rd_valid=1 after edge N. With rd_en=0, rd_valid=0 and R0/B0/G0 hold their last value.
- A write at edge N is readable from that bank once the bank becomes front, after the swap.
- Swap: frame_end at edge N while in PEND gives front_sel toggled and swap_done=1 after edge N+1.
  - A read sampled at edge N or N+1 uses the old front bank.
  - A write at edge N or N+1 goes to the old back bank, which becomes the new front bank.
- Clear: clr_start at edge N sets clr_busy after N. Addresses 0..DEPTH-1 are written at edges N+1..N+DEPTH. clr_busy falls after edge N+DEPTH.
- Asynchronous reset takes effect immediately, mid-read or mid-swap, and returns all state to its reset values.

## Test plan
- Reset, then write addr 5 = {G=0x33, B=0x22, R=0x11} with wr_be=3'b111, then swap_req followed by frame_end. Read addr 5 -> R0=0x11, B0=0x22, G0=0x33, rd_valid=1 one cycle after rd_en.
- Write addr 7 = 0xAABBCC with wr_be=3'b111, then 0x000000 with wr_be=3'b010, then swap -> read gives R=0xCC, B=0x00, G=0xAA.
- rd_addr=DEPTH and wr_addr=DEPTH+3 -> read returns 0/0/0 with rd_valid=1; the write leaves bank contents unchanged.
- swap_req, then rd_en on the same cycle as frame_end -> old-bank data returned; front_sel toggles and swap_done pulses one cycle after frame_end. A second swap_req while in PEND produces no extra swap.
- clr_start with DEPTH=16 -> clr_busy high for 16 cycles. A wr_en during the clear is dropped. A frame_end during the clear is deferred and the swap commits on the next frame_end. After the swap, every address reads 0.
- Assert reset mid-clear and mid-PEND -> all outputs at reset values immediately; after release, no swap occurs on frame_end.
